// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into 16-bit words and streams them with sequential write addresses
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        cond,
    input  logic [3:0]        op_code,
    input  logic [2:0]        dest_reg,
    input  logic [2:0]        src_reg_1,
    input  logic [2:0]        src_reg_2,
    input  logic              use_shift,
    input  logic [6:0]        shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W:0]   instr_count,
    output logic              wrapped,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t      state, state_nxt;
    logic        accept;
    logic        xfer;
    logic [15:0] enc_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && in_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                // stay here through the done cycle so a start coinciding with done is ignored
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept   = in_valid && in_ready;
        xfer     = out_valid && out_ready;
        enc_word = {cond, op_code, dest_reg,
                    use_shift ? shift : {src_reg_1, src_reg_2, 1'b0}};
    end

    // out_addr always holds the address of the held word, or of the next word when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_word    <= '0;
            out_addr    <= START;
            instr_count <= '0;
            wrapped     <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (state == FLUSH) && xfer;
            if (state == IDLE && start) begin
                out_addr    <= START;
                instr_count <= '0;
                wrapped     <= 1'b0;
            end else if (xfer) begin
                out_addr    <= out_addr + ADDR_W'(1);
                instr_count <= instr_count + (ADDR_W+1)'(1);
                if (out_addr == ADDR_MAX) wrapped <= 1'b1;
            end
            if (accept) begin
                out_word  <= enc_word;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

    localparam int AW    = 8;
    localparam int START = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, in_valid = 1'b0, in_last = 1'b0, use_shift = 1'b0, out_ready = 1'b0;
    logic [1:0]    cond = '0;
    logic [3:0]    op_code = '0;
    logic [2:0]    dest_reg = '0, src_reg_1 = '0, src_reg_2 = '0;
    logic [6:0]    shift = '0;
    logic          in_ready, out_valid, wrapped, done;
    logic [15:0]   out_word;
    logic [AW-1:0] out_addr;
    logic [AW:0]   instr_count;

    logic          w_start = 1'b0, w_in_valid = 1'b0, w_in_last = 1'b0, w_use_shift = 1'b0, w_out_ready = 1'b1;
    logic [1:0]    w_cond = '0;
    logic [3:0]    w_op = '0;
    logic [2:0]    w_dest = '0, w_s1 = '0, w_s2 = '0;
    logic [6:0]    w_shift = '0;
    logic          w_in_ready, w_out_valid, w_wrapped, w_done;
    logic [15:0]   w_out_word;
    logic [1:0]    w_out_addr;
    logic [2:0]    w_instr_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] w;
        int          a;
        logic        l;
    } exp_t;
    exp_t q[$];
    int   pushed = 0;
    int   xfers = 0;
    logic pend_done = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW), .START_ADDR(START)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .cond(cond), .op_code(op_code), .dest_reg(dest_reg),
        .src_reg_1(src_reg_1), .src_reg_2(src_reg_2), .use_shift(use_shift), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .instr_count(instr_count), .wrapped(wrapped), .done(done)
    );

    instr_encoder #(.ADDR_W(2), .START_ADDR(3)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_last(w_in_last), .cond(w_cond), .op_code(w_op), .dest_reg(w_dest),
        .src_reg_1(w_s1), .src_reg_2(w_s2), .use_shift(w_use_shift), .shift(w_shift),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_word(w_out_word), .out_addr(w_out_addr),
        .instr_count(w_instr_count), .wrapped(w_wrapped), .done(w_done)
    );

    function automatic logic [15:0] model_word(int c, int o, int d, int s1, int s2, int us, int sh);
        int low;
        low = (us != 0) ? sh : (s1 * 16 + s2 * 2);
        return 16'(c * 16384 + o * 1024 + d * 128 + low);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every negedge, compare the held word against the oldest accepted bundle
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pushed    = 0;
            xfers     = 0;
            pend_done = 1'b0;
        end else begin
            chk("done_pulse", done, pend_done);
            if (pend_done) begin
                chk("count_at_done", instr_count, xfers);
                chk("wrapped_at_done", wrapped, (START + xfers) >= (1 << AW));
            end
            pend_done = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", out_valid, 1'b0);
                end else begin
                    chk("word", out_word, q[0].w);
                    chk("addr", out_addr, q[0].a);
                    if (out_ready) begin
                        xfers++;
                        pend_done = q[0].l;
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{model_word(cond, op_code, dest_reg, src_reg_1, src_reg_2, use_shift, shift),
                              (START + pushed) % (1 << AW), in_last});
                pushed++;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_addr", out_addr, START);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic start_prog();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        xfers = 0;
        pushed = 0;
    endtask

    task automatic send(input int c, input int o, input int d, input int s1, input int s2,
                        input int us, input int sh, input logic l, output int cyc);
        logic ok;
        cond = 2'(c); op_code = 4'(o); dest_reg = 3'(d);
        src_reg_1 = 3'(s1); src_reg_2 = 3'(s2); use_shift = us[0]; shift = 7'(sh);
        in_last = l;
        in_valid = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int exp_count);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", done, 1);
        chk("done_count", instr_count, exp_count);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // single register-form word
        start_prog();
        send(3, 5, 3, 6, 2, 0, 0, 1'b1, cyc);
        idle();
        @(negedge clk);
        chk("lit_d5e4", out_word, 16'hD5E4);
        chk("lit_addr0", out_addr, 0);
        chk("lit_valid", out_valid, 1);
        chk("model_pin_d5e4", model_word(3, 5, 3, 6, 2, 0, 0), 16'hD5E4);
        @(negedge clk);
        chk("lit_done", done, 1);
        chk("lit_count1", instr_count, 1);

        // shift form, src fields must be ignored
        start_prog();
        send(0, 10, 7, 7, 7, 1, 7'h55, 1'b1, cyc);
        idle();
        @(negedge clk);
        chk("lit_2bd5", out_word, 16'h2BD5);
        chk("model_pin_2bd5", model_word(0, 10, 7, 7, 7, 1, 85), 16'h2BD5);
        wait_done(1);

        // back-to-back burst
        start_prog();
        for (int i = 0; i < 4; i++) begin
            send(i, i + 1, i, 7 - i, i, 0, 0, i == 3, cyc);
            chk("burst_one_cycle", cyc, 1);
        end
        idle();
        wait_done(4);

        // backpressure with a held word
        start_prog();
        out_ready = 1'b0;
        send(1, 2, 3, 4, 5, 0, 0, 1'b0, cyc);
        cond = 2'd2; op_code = 4'd9; dest_reg = 3'd1; use_shift = 1'b1; shift = 7'h12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_word", out_word, 16'h49CA);
            chk("stall_addr", out_addr, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(2, 9, 1, 0, 0, 1, 7'h12, 1'b1, cyc);
        chk("release_accept", cyc, 1);
        idle();
        wait_done(2);

        // async reset while FLUSH holds a stalled word
        start_prog();
        out_ready = 1'b0;
        send(1, 1, 1, 1, 1, 0, 0, 1'b1, cyc);
        idle();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
        end
        start_prog();
        send(0, 3, 2, 1, 0, 0, 0, 1'b1, cyc);
        idle();
        wait_done(1);

        // address wrap on ADDR_W=2, START_ADDR=3
        @(posedge clk);
        #1;
        w_start = 1'b1;
        @(posedge clk);
        #1;
        w_start = 1'b0;
        w_in_valid = 1'b1; w_cond = 2'd1; w_op = 4'd2; w_dest = 3'd3; w_s1 = 3'd4; w_s2 = 3'd5;
        @(negedge clk);
        chk("w_in_ready", w_in_ready, 1);
        @(posedge clk);
        #1;
        w_in_last = 1'b1; w_use_shift = 1'b1; w_cond = 2'd2; w_op = 4'hF; w_dest = 3'd0; w_shift = 7'h7F;
        @(negedge clk);
        chk("w_addr3", w_out_addr, 3);
        chk("w_word_a", w_out_word, 16'h49CA);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        w_in_last = 1'b0;
        @(negedge clk);
        chk("w_addr0", w_out_addr, 0);
        chk("w_word_b", w_out_word, 16'hBC7F);
        @(negedge clk);
        chk("w_done", w_done, 1);
        chk("w_count", w_instr_count, 2);
        chk("w_wrapped", w_wrapped, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder: packs cond, op_code, register and shift fields into the 16-bit instruction word.
- Streams the encoded words, each tagged with a sequential write address, toward instruction memory.
- Used by the program loader and by test harnesses to build programs.
- One registered pipeline stage with valid/ready on both sides, plus a small control FSM that frames a program (start ... last).

Parameters:
ADDR_W, 8, width of instruction-memory write address
START_ADDR, 0, address assigned to the first word of each program (must be < 2**ADDR_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a new program; honoured only in IDLE
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
in_last  input  1  bundle is the final instruction of the program
cond  input  2  condition field
op_code  input  4  opcode field
dest_reg  input  3  destination register
src_reg_1  input  3  source register 1
src_reg_2  input  3  source register 2
use_shift  input  1  1: low 7 bits carry shift; 0: carry src_reg_1/src_reg_2
shift  input  7  shift/immediate value
out_valid  output  1  encoded word valid
out_ready  input  1  memory side accepts word
out_word  output  16  encoded instruction
out_addr  output  ADDR_W  write address for out_word
instr_count  output  ADDR_W+1  words emitted in the current program
wrapped  output  1  sticky: address counter wrapped during this program
done  output  1  one-cycle pulse after the last word transfers

Behaviour:
- Word format:
  - out_word[15:14]=cond, [13:10]=op_code, [9:7]=dest_reg.
  - use_shift=0: [6:4]=src_reg_1, [3:1]=src_reg_2, [0]=0.
  - use_shift=1: [6:0]=shift; src_reg fields are ignored.
- Reset (async, any state, mid-transfer included):
  - state=IDLE, out_valid=0, out_word=0, out_addr=START_ADDR, instr_count=0, wrapped=0, done=0, in_ready=0.
  - A held word is discarded.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready=0.
  - start=1 -> RUN next cycle; out_addr<=START_ADDR, instr_count<=0, wrapped<=0.
- RUN:
  - in_ready = !out_valid || out_ready (combinational; full throughput: one word per cycle).
  - Accept when in_valid && in_ready: the encoded word is registered onto out_word; out_valid=1 the next cycle. Latency is 1 cycle.
  - Accept with in_last=1 -> FLUSH.
  - start is ignored.
- FLUSH:
  - in_ready=0.
  - When the held word transfers (out_valid && out_ready): done=1 for exactly the following cycle, then IDLE.
- Output transfer (out_valid && out_ready):
  - out_addr increments; from 2**ADDR_W-1 it wraps to 0 and sets wrapped=1 (sticky until next start).
  - instr_count increments; it does not wrap within 2**ADDR_W words.
  - Transfer and new accept in the same cycle: out_word/out_addr update to the new word with no bubble, and out_valid stays 1.
  - Transfer without a new accept: out_valid<=0.
- Stall: while out_valid && !out_ready, out_word and out_addr hold stable.
- in_valid may deassert at any time; a bundle is consumed only on handshake.
- start while in RUN/FLUSH has no effect. start in the same cycle as done returns to IDLE first, so it must be re-asserted.

Test Plan:
- Reset, start, one bundle {cond=2'b11, op=4'h5, dest=3, src1=6, src2=2, use_shift=0, last=1}, out_ready=1:
  - out_word=16'hD5E4 at out_addr=0 one cycle after accept.
  - done pulses the cycle after the transfer; instr_count=1.
- Shift form {cond=0, op=4'hA, dest=7, shift=7'h55, use_shift=1}:
  - out_word=16'h2BD5.
  - The src fields (set to 7,7) do not affect the word.
- Back-to-back burst of 4 bundles, out_ready=1:
  - 4 consecutive out_valid cycles at addresses 0,1,2,3; in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles with a word held:
  - in_ready=0; out_word/out_addr stable.
  - On release the next bundle is accepted the same cycle.
- Wrap: ADDR_W=2, START_ADDR=3, 2 words:
  - addresses 3 then 0; wrapped=1; instr_count=2.
- Async reset asserted mid-FLUSH with a stalled word:
  - All outputs go to reset values immediately; no done pulse.
  - A new start works normally afterward.
